siso_rowunit_oms: RTL and testbench

Parametrised offset-min-sum row processing unit for the layered LDPC decoder. It takes one row of Wc LLR lanes per accepted request and reads the row's compressed check-to-variable message from an internal E store. It produces updated LLRs and delta messages over a 4-stage pipeline, then writes the new compressed message back. Compared with the fixed row unit, it adds a valid/ready input handshake, a read-after-write hazard stall, an optional offset correction, a first-visit (empty-entry) rule, a codeword clear, and out-of-range address trapping.

---
 rtl/siso_rowunit_oms.sv | 274 +++++++++++++++++++++++++++
 tb/tb_siso_rowunit_oms.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/siso_rowunit_oms.sv
// siso_rowunit_oms: offset-min-sum LDPC row unit with a valid/ready request port,
// a read-after-write stall on in-flight rows, a compressed E store with
// first-visit decode, codeword clear and out-of-range address trapping.
module siso_rowunit_oms #(
    parameter int Wc        = 32,
    parameter int WCBITS    = 5,
    parameter int W         = 6,
    parameter int LAYERS    = 2,
    parameter int LAYERBITS = 1,
    parameter int ADDRWIDTH = 5,
    parameter int ADDRDEPTH = 20,
    parameter int OFFSET    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 offset_en_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [LAYERBITS-1:0] in_layer_i,
    input  logic [ADDRWIDTH-1:0] in_addr_i,
    input  logic [Wc*W-1:0]      in_llr_i,
    output logic                 out_valid_o,
    output logic [LAYERBITS-1:0] out_layer_o,
    output logic [ADDRWIDTH-1:0] out_addr_o,
    output logic [Wc*W-1:0]      out_llr_o,
    output logic [Wc*W-1:0]      out_d_o,
    output logic                 err_addr_o
);
    localparam int WABS      = W - 1;
    localparam int ECOMPSIZE = 2 * WABS + WCBITS + Wc;
    localparam int DEPTH     = LAYERS * ADDRDEPTH;
    localparam int IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TAGW      = LAYERBITS + ADDRWIDTH;
    localparam logic [WABS-1:0] MAXMAG = {WABS{1'b1}};

    // Clip a W+1 bit value to the symmetric range +/-(2^(W-1)-1).
    function automatic logic [W-1:0] sat_f(input logic signed [W:0] x);
        logic signed [W:0] hi;
        logic signed [W:0] lo;
        hi = $signed({2'b00, MAXMAG});
        lo = -hi;
        if (x > hi) begin
            return hi[W-1:0];
        end else if (x < lo) begin
            return lo[W-1:0];
        end else begin
            return x[W-1:0];
        end
    endfunction

    // Sign-extend one lane to W+1 bits so sums/differences cannot wrap.
    function automatic logic signed [W:0] sext_f(input logic [W-1:0] v);
        return $signed({v[W-1], v});
    endfunction

    // Expand a compressed message into per-lane R values; an empty entry is all zero.
    function automatic logic [Wc*W-1:0] decode_f(input logic [ECOMPSIZE-1:0] comp, input logic vld);
        logic [WABS-1:0]   m1;
        logic [WABS-1:0]   m2;
        logic [WABS-1:0]   mag;
        logic [WCBITS-1:0] ix;
        logic [Wc-1:0]     sg;
        logic              par;
        logic [W-1:0]      v;
        logic [Wc*W-1:0]   r;
        {m1, m2, ix, sg} = comp;
        par = ^sg;
        r   = {(Wc*W){1'b0}};
        for (int i = 0; i < Wc; i++) begin
            mag = (int'(ix) == i) ? m2 : m1;
            v   = {1'b0, mag};
            v   = (par ^ sg[i]) ? -v : v;
            r[i*W +: W] = v;
        end
        return vld ? r : {(Wc*W){1'b0}};
    endfunction

    // Pipeline and store state
    logic                 s1_vld_q, s2_vld_q, s3_vld_q, out_vld_q, err_addr_q;
    logic                 s1_vld_d, s2_vld_d, s3_vld_d, out_vld_d, err_addr_d;
    logic [TAGW-1:0]      s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;
    logic [Wc*W-1:0]      s1_llr_q, s1_rold_q, s2_rold_q, s3_rold_q;
    logic [Wc*W-1:0]      s2_q_q, s3_q_q, out_llr_q, out_d_q;
    logic [Wc-1:0]        s2_sgn_q, s3_sgn_q;
    logic [Wc*WABS-1:0]   s2_abs_q;
    logic [WABS-1:0]      s3_min1_q, s3_min2_q;
    logic [WCBITS-1:0]    s3_idx_q;
    logic [ECOMPSIZE-1:0] e_mem_q [DEPTH];
    logic [DEPTH-1:0]     e_vld_q;

    // Request-side decode: tag, range, RAW hazard against S1..S3
    logic            in_range_s, hazard_s, accept_s, take_s;
    logic [TAGW-1:0] in_tag_s;
    logic [IDXW-1:0] rd_idx_s, wr_idx_s;
    logic [Wc*W-1:0] rold_in_s;

    assign in_tag_s   = {in_layer_i, in_addr_i};
    assign in_range_s = (32'(in_layer_i) < 32'(LAYERS)) && (32'(in_addr_i) < 32'(ADDRDEPTH));
    assign hazard_s   = (s1_vld_q && (s1_tag_q == in_tag_s)) ||
                        (s2_vld_q && (s2_tag_q == in_tag_s)) ||
                        (s3_vld_q && (s3_tag_q == in_tag_s));
    assign in_ready_o = ~clear_i & ~(in_valid_i & in_range_s & hazard_s);
    assign accept_s   = in_valid_i & in_ready_o;
    assign take_s     = accept_s & in_range_s;
    assign rd_idx_s   = in_range_s ? IDXW'(32'(in_layer_i) * 32'(ADDRDEPTH) + 32'(in_addr_i))
                                   : {IDXW{1'b0}};
    assign wr_idx_s   = IDXW'(32'(s3_tag_q[TAGW-1 -: LAYERBITS]) * 32'(ADDRDEPTH)
                              + 32'(s3_tag_q[ADDRWIDTH-1:0]));
    assign rold_in_s  = decode_f(e_mem_q[rd_idx_s], e_vld_q[rd_idx_s]);

    // S2 datapath: Q = L - Rold saturated, split into sign and magnitude
    logic [Wc*W-1:0]    s2_q_d;
    logic [Wc-1:0]      s2_sgn_d;
    logic [Wc*WABS-1:0] s2_abs_d;
    logic [W-1:0]       qv_s, qn_s;
    always_comb begin
        s2_q_d   = {(Wc*W){1'b0}};
        s2_sgn_d = {Wc{1'b0}};
        s2_abs_d = {(Wc*WABS){1'b0}};
        qv_s     = {W{1'b0}};
        qn_s     = {W{1'b0}};
        for (int i = 0; i < Wc; i++) begin
            qv_s = sat_f(sext_f(s1_llr_q[i*W +: W]) - sext_f(s1_rold_q[i*W +: W]));
            qn_s = -qv_s;
            s2_q_d[i*W +: W]         = qv_s;
            s2_sgn_d[i]              = qv_s[W-1];
            s2_abs_d[i*WABS +: WABS] = qv_s[W-1] ? qn_s[WABS-1:0] : qv_s[WABS-1:0];
        end
    end

    // S3 datapath: two smallest magnitudes (lowest lane wins ties) and optional offset
    logic [WABS-1:0]   min1_s, min2_s, min1_d, min2_d, mag_s;
    logic [WCBITS-1:0] idx_d;
    always_comb begin
        min1_s = MAXMAG;
        min2_s = MAXMAG;
        idx_d  = {WCBITS{1'b0}};
        mag_s  = {WABS{1'b0}};
        for (int i = 0; i < Wc; i++) begin
            mag_s  = s2_abs_q[i*WABS +: WABS];
            idx_d  = (mag_s < min1_s) ? WCBITS'(i) : idx_d;
            min1_s = (mag_s < min1_s) ? mag_s : min1_s;
        end
        for (int i = 0; i < Wc; i++) begin
            mag_s  = s2_abs_q[i*WABS +: WABS];
            min2_s = ((WCBITS'(i) != idx_d) && (mag_s < min2_s)) ? mag_s : min2_s;
        end
        if (offset_en_i) begin
            min1_d = (32'(min1_s) > 32'(OFFSET)) ? (min1_s - WABS'(OFFSET)) : {WABS{1'b0}};
            min2_d = (32'(min2_s) > 32'(OFFSET)) ? (min2_s - WABS'(OFFSET)) : {WABS{1'b0}};
        end else begin
            min1_d = min1_s;
            min2_d = min2_s;
        end
    end

    // Output datapath: decode Rnew from the new word, form updated LLR and delta
    logic [ECOMPSIZE-1:0] new_comp_s;
    logic [Wc*W-1:0]      rnew_s, llr_new_s, d_new_s;
    assign new_comp_s = {s3_min1_q, s3_min2_q, s3_idx_q, s3_sgn_q};
    assign rnew_s     = decode_f(new_comp_s, 1'b1);
    always_comb begin
        llr_new_s = {(Wc*W){1'b0}};
        d_new_s   = {(Wc*W){1'b0}};
        for (int i = 0; i < Wc; i++) begin
            llr_new_s[i*W +: W] = sat_f(sext_f(s3_q_q[i*W +: W]) + sext_f(rnew_s[i*W +: W]));
            d_new_s[i*W +: W]   = sat_f(sext_f(rnew_s[i*W +: W]) - sext_f(s3_rold_q[i*W +: W]));
        end
    end

    // Next-state of stage valids and the sticky address error; clear squashes everything
    always_comb begin
        s1_vld_d   = 1'b0;
        s2_vld_d   = 1'b0;
        s3_vld_d   = 1'b0;
        out_vld_d  = 1'b0;
        if (clear_i) begin
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            s3_vld_d  = 1'b0;
            out_vld_d = 1'b0;
        end else begin
            s1_vld_d  = take_s;
            s2_vld_d  = s1_vld_q;
            s3_vld_d  = s2_vld_q;
            out_vld_d = s3_vld_q;
        end
        err_addr_d = err_addr_q | (accept_s & ~in_range_s);
    end

    // Control registers: stage valids, result strobe, sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            err_addr_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s3_vld_q   <= s3_vld_d;
            out_vld_q  <= out_vld_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Pipeline data registers; output data only load on a real result and hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_tag_q  <= '0; s1_llr_q  <= '0; s1_rold_q <= '0;
            s2_tag_q  <= '0; s2_q_q    <= '0; s2_sgn_q  <= '0; s2_abs_q <= '0; s2_rold_q <= '0;
            s3_tag_q  <= '0; s3_q_q    <= '0; s3_sgn_q  <= '0; s3_rold_q <= '0;
            s3_min1_q <= '0; s3_min2_q <= '0; s3_idx_q  <= '0;
            out_tag_q <= '0; out_llr_q <= '0; out_d_q   <= '0;
        end else begin
            if (take_s) begin
                s1_tag_q  <= in_tag_s;
                s1_llr_q  <= in_llr_i;
                s1_rold_q <= rold_in_s;
            end else begin
                s1_tag_q  <= s1_tag_q;
            end
            s2_tag_q  <= s1_tag_q;
            s2_q_q    <= s2_q_d;
            s2_sgn_q  <= s2_sgn_d;
            s2_abs_q  <= s2_abs_d;
            s2_rold_q <= s1_rold_q;
            s3_tag_q  <= s2_tag_q;
            s3_q_q    <= s2_q_q;
            s3_sgn_q  <= s2_sgn_q;
            s3_rold_q <= s2_rold_q;
            s3_min1_q <= min1_d;
            s3_min2_q <= min2_d;
            s3_idx_q  <= idx_d;
            if (out_vld_d) begin
                out_tag_q <= s3_tag_q;
                out_llr_q <= llr_new_s;
                out_d_q   <= d_new_s;
            end else begin
                out_tag_q <= out_tag_q;
            end
        end
    end

    // E store valid bits: clear empties the store, a result marks its row valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e_vld_q <= '0;
        end else if (clear_i) begin
            e_vld_q <= '0;
        end else if (out_vld_d) begin
            e_vld_q[wr_idx_s] <= 1'b1;
        end else begin
            e_vld_q <= e_vld_q;
        end
    end

    // E store payload: compressed message written back with each result
    always_ff @(posedge clk_i) begin
        if (out_vld_d) begin
            e_mem_q[wr_idx_s] <= new_comp_s;
        end
    end

    assign out_valid_o = out_vld_q;
    assign out_layer_o = out_tag_q[TAGW-1 -: LAYERBITS];
    assign out_addr_o  = out_tag_q[ADDRWIDTH-1:0];
    assign out_llr_o   = out_llr_q;
    assign out_d_o     = out_d_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_siso_rowunit_oms.sv
// Directed bench for siso_rowunit_oms with a 4-lane, 6-bit configuration.
module tb_siso_rowunit_oms;
    localparam int Wc = 4, WCBITS = 2, W = 6, LAYERS = 2, LAYERBITS = 1;
    localparam int ADDRWIDTH = 5, ADDRDEPTH = 20, OFFSET = 1;

    logic        clk = 1'b0;
    logic        rst_n, clear, offset_en, in_valid, in_ready;
    logic [0:0]  in_layer;
    logic [4:0]  in_addr;
    logic [23:0] in_llr;
    logic        out_valid;
    logic [0:0]  out_layer;
    logic [4:0]  out_addr;
    logic [23:0] out_llr, out_d;
    logic        err_addr;
    int          checks = 0;
    int          errors = 0;

    siso_rowunit_oms #(.Wc(Wc), .WCBITS(WCBITS), .W(W), .LAYERS(LAYERS), .LAYERBITS(LAYERBITS),
                       .ADDRWIDTH(ADDRWIDTH), .ADDRDEPTH(ADDRDEPTH), .OFFSET(OFFSET)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .offset_en_i(offset_en),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_layer_i(in_layer),
        .in_addr_i(in_addr), .in_llr_i(in_llr), .out_valid_o(out_valid),
        .out_layer_o(out_layer), .out_addr_o(out_addr), .out_llr_o(out_llr),
        .out_d_o(out_d), .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;

    // Pack lanes 0..3 (lane 0 in the low bits).
    function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
        logic [5:0] a6, b6, c6, d6;
        a6 = 6'(a); b6 = 6'(b); c6 = 6'(c); d6 = 6'(d);
        return {d6, c6, b6, a6};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return 1 time unit after its accepting edge.
    task automatic send(input logic [0:0] ly, input logic [4:0] ad, input logic [23:0] l);
        int n;
        n = 0;
        in_layer = ly; in_addr = ad; in_llr = l; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("send_timeout", 24'(n), 24'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [0:0] ly, input logic [4:0] ad,
                              input logic [23:0] llr, input logic [23:0] d);
        check({tag, "_valid"}, 24'(out_valid), 24'(1));
        check({tag, "_layer"}, 24'(out_layer), 24'(ly));
        check({tag, "_addr"},  24'(out_addr),  24'(ad));
        check({tag, "_llr"},   out_llr, llr);
        check({tag, "_d"},     out_d,   d);
    endtask

    initial begin
        logic [23:0] lfv, lsat, fv_llr, fv_d, rv_llr, rv_d, sat31;
        lfv    = pk(5, -3, 7, 2);
        lsat   = pk(31, 31, 31, 31);
        fv_llr = pk(3, -1, 5, -1);
        fv_d   = pk(-2, 2, -2, -3);
        rv_llr = pk(2, 0, 4, 0);
        rv_d   = pk(-3, 3, -3, -2);
        sat31  = pk(31, 31, 31, 31);

        rst_n = 1'b0; clear = 1'b0; offset_en = 1'b0; in_valid = 1'b0;
        in_layer = 1'b0; in_addr = 5'd0; in_llr = 24'd0;
        tick(); tick();
        check("rst_out_valid", 24'(out_valid), 24'(0));
        check("rst_out_llr", out_llr, 24'd0);
        check("rst_err", 24'(err_addr), 24'(0));
        rst_n = 1'b1;
        tick();
        check("rst_ready", 24'(in_ready), 24'(1));

        // First visit: result appears 4 cycles after accept, as a single strobe
        send(1'b0, 5'd0, lfv);
        tick(); tick();
        check("fv_early", 24'(out_valid), 24'(0));
        tick();
        expect_out("fv", 1'b0, 5'd0, fv_llr, fv_d);
        tick();
        check("fv_strobe", 24'(out_valid), 24'(0));
        check("fv_hold", out_llr, fv_llr);

        // Revisit of the same row reads back the stored message
        send(1'b0, 5'd0, lfv);
        tick(); tick(); tick();
        expect_out("rv", 1'b0, 5'd0, rv_llr, rv_d);

        // Offset correction on a fresh row
        offset_en = 1'b1;
        send(1'b1, 5'd5, lfv);
        tick(); tick(); tick();
        expect_out("ofs", 1'b1, 5'd5, pk(4, -2, 6, 0), pk(-1, 1, -1, -2));
        offset_en = 1'b0;
        tick();

        // Hazard: held request to row 3 stalls until the first one has left S3
        in_layer = 1'b0; in_addr = 5'd3; in_llr = lfv; in_valid = 1'b1;
        #1;
        check("hz_ready_e0", 24'(in_ready), 24'(1));
        @(posedge clk); #1;
        check("hz_stall_s1", 24'(in_ready), 24'(0));
        tick();
        check("hz_stall_s2", 24'(in_ready), 24'(0));
        tick();
        check("hz_stall_s3", 24'(in_ready), 24'(0));
        tick();
        check("hz_ready_e4", 24'(in_ready), 24'(1));
        expect_out("hz_first", 1'b0, 5'd3, fv_llr, fv_d);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        expect_out("hz_second", 1'b0, 5'd3, rv_llr, rv_d);

        // Back-to-back distinct rows (addr 1/2 in both layers), incl. saturation
        for (int k = 0; k < 4; k++) begin
            in_layer = 1'(k / 2); in_addr = 5'(1 + (k % 2));
            in_llr = (k % 2 == 0) ? lfv : lsat; in_valid = 1'b1;
            #1;
            check("bb_ready", 24'(in_ready), 24'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        expect_out("bb0", 1'b0, 5'd1, fv_llr, fv_d);
        tick();
        expect_out("bb1_sat", 1'b0, 5'd2, sat31, sat31);
        tick();
        expect_out("bb2", 1'b1, 5'd1, fv_llr, fv_d);
        tick();
        expect_out("bb3_sat", 1'b1, 5'd2, sat31, sat31);

        // Out-of-range address: accepted, dropped, sticky error
        in_layer = 1'b0; in_addr = 5'd20; in_llr = lfv; in_valid = 1'b1;
        #1;
        check("oor_ready", 24'(in_ready), 24'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("oor_err", 24'(err_addr), 24'(1));
        for (int k = 0; k < 4; k++) begin
            check("oor_no_out", 24'(out_valid), 24'(0));
            tick();
        end

        // Clear squashes an in-flight row and empties the store
        send(1'b0, 5'd7, lfv);
        clear = 1'b1;
        #1;
        check("clr_ready", 24'(in_ready), 24'(0));
        @(posedge clk); #1;
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("clr_no_out", 24'(out_valid), 24'(0));
            tick();
        end
        check("clr_err_kept", 24'(err_addr), 24'(1));
        send(1'b0, 5'd0, lfv);
        tick(); tick(); tick();
        expect_out("clr_fv", 1'b0, 5'd0, fv_llr, fv_d);

        // Asynchronous reset with a row in flight
        send(1'b0, 5'd9, lfv);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 24'(out_valid), 24'(0));
        check("ar_llr", out_llr, 24'd0);
        check("ar_d", out_d, 24'd0);
        check("ar_tag", {18'd0, out_layer, out_addr}, 24'd0);
        check("ar_err", 24'(err_addr), 24'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_ready", 24'(in_ready), 24'(1));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ar_no_out", 24'(out_valid), 24'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
